// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS DATA_W-bit registers with byte strobes.
// Optional feature macro AXIL_REGFILE_PROT_EN: unprivileged access to index 0 returns SLVERR.
module axi_lite_regfile_slave #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [2:0]          awprot,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [2:0]          arprot,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]  aw_idx_q;
    logic              aw_p0_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic [IDX_W-1:0]  aw_idx, ar_idx, c_idx;
    logic              c_p0;
    logic [DATA_W-1:0] c_data;
    logic [STRB_W-1:0] c_strb;
    logic              aw_hs, w_hs, ar_hs, commit, c_err, r_err;

    assign aw_idx = awaddr[ADDR_W-1:OFF_W];
    assign ar_idx = araddr[ADDR_W-1:OFF_W];

    // Commit merges whichever half was latched with the half arriving live.
    assign c_idx  = (w_state == W_ADDR) ? aw_idx_q : aw_idx;
    assign c_p0   = (w_state == W_ADDR) ? aw_p0_q  : awprot[0];
    assign c_data = (w_state == W_DATA) ? w_data_q : wdata;
    assign c_strb = (w_state == W_DATA) ? w_strb_q : wstrb;

`ifdef AXIL_REGFILE_PROT_EN
    assign c_err = ({1'b0, c_idx} >= NREG) || (c_idx == '0 && !c_p0);
    assign r_err = ({1'b0, ar_idx} >= NREG) || (ar_idx == '0 && !arprot[0]);
    logic unused_bits;
    assign unused_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0], awprot[2:1], arprot[2:1]};
`else
    assign c_err = ({1'b0, c_idx} >= NREG);
    assign r_err = ({1'b0, ar_idx} >= NREG);
    logic unused_bits;
    assign unused_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0], awprot, arprot, c_p0};
`endif

    assign awready = !areset && (w_state == W_IDLE || w_state == W_DATA);
    assign wready  = !areset && (w_state == W_IDLE || w_state == W_ADDR);
    assign arready = !areset && (r_state == R_IDLE);
    assign bvalid  = (w_state == W_RESP);
    assign rvalid  = (r_state == R_RESP);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_ADDR;
                end else if (w_hs) begin
                    w_next = W_DATA;
                end
            end
            W_ADDR: if (w_hs) begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_DATA: if (aw_hs) begin
                commit = 1'b1;
                w_next = W_RESP;
            end
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            bresp    <= RESP_OKAY;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
            aw_idx_q <= '0;
            aw_p0_q  <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            if (aw_hs) begin
                aw_idx_q <= aw_idx;
                aw_p0_q  <= awprot[0];
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                bresp <= c_err ? RESP_SLVERR : RESP_OKAY;
                if (!c_err)
                    for (int b = 0; b < STRB_W; b++)
                        if (c_strb[b]) regs[c_idx[RIDX_W-1:0]][b*8 +: 8] <= c_data[b*8 +: 8];
            end
            // Reads sample the array before this edge's commit lands.
            if (ar_hs) begin
                rdata <= r_err ? '0 : regs[ar_idx[RIDX_W-1:0]];
                rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave with default parameters.
module tb_axi_lite_regfile_slave;

    logic        aclk, areset;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_vec = 0;
    int n_err = 0;

    axi_lite_regfile_slave dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic b_accept();
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input logic [1:0] exp_resp);
        awaddr = a; awprot = p; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        chk("wr_readies", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid", bvalid, 1'b1);
        chk("wr_bresp", bresp, exp_resp);
        b_accept();
    endtask

    task automatic rd(input logic [7:0] a, input logic [2:0] p,
                      input logic [31:0] exp_d, input logic [1:0] exp_resp);
        araddr = a; arprot = p; arvalid = 1'b1;
        chk("rd_arready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        chk("rd_rvalid", rvalid, 1'b1);
        chk("rd_arready_busy", arready, 1'b0);
        chk("rd_rdata", rdata, exp_d);
        chk("rd_rresp", rresp, exp_resp);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rd_rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        tick();
        tick();
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid}, 2'b00);
        areset = 1'b0;
        #1;
        chk("post_rst_readies", {awready, wready, arready}, 3'b111);
        chk("post_rst_resps", {bresp, rresp}, 4'b0000);
        chk("post_rst_rdata", rdata, 32'h0);

        // Same-cycle AW+W, then read back; offset bits ignored
        wr(8'h04, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
        rd(8'h04, 3'b000, 32'hDEADBEEF, 2'b00);
        rd(8'h07, 3'b000, 32'hDEADBEEF, 2'b00);

        // Byte strobes
        wr(8'h08, 32'h11223344, 4'hF, 3'b000, 2'b00);
        wr(8'h08, 32'hAABBCCDD, 4'h5, 3'b000, 2'b00);
        rd(8'h08, 3'b000, 32'h11BB33DD, 2'b00);
        wr(8'h08, 32'hFFFFFFFF, 4'h0, 3'b000, 2'b00);
        rd(8'h08, 3'b000, 32'h11BB33DD, 2'b00);

        // W two cycles before AW, bready held low
        wdata = 32'hC0C05A5A; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wdata_state_readies", {awready, wready, bvalid}, 3'b100);
        tick();
        awaddr = 8'h0C; awprot = 3'b000; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'h0BADF00D; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("wresp_hold_bvalid", bvalid, 1'b1);
            chk("wresp_hold_bresp", bresp, 2'b00);
            chk("wresp_hold_readies", {awready, wready}, 2'b00);
            tick();
        end
        wvalid = 1'b0;
        b_accept();
        rd(8'h0C, 3'b000, 32'hC0C05A5A, 2'b00);

        // AW before W with partial strobe
        awaddr = 8'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("waddr_state_readies", {awready, wready, bvalid}, 3'b010);
        wdata = 32'h55AA55AA; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("waddr_bvalid", bvalid, 1'b1);
        b_accept();
        rd(8'h10, 3'b000, 32'h000055AA, 2'b00);

        // Out of range
        wr(8'h40, 32'h12345678, 4'hF, 3'b000, 2'b10);
        rd(8'h40, 3'b000, 32'h0, 2'b10);
        rd(8'h00, 3'b000, 32'h0, 2'b00);
        rd(8'h04, 3'b000, 32'hDEADBEEF, 2'b00);

        // Read and commit to the same index on one edge
        awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 8'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_edge_rdata", rdata, 32'hDEADBEEF);
        chk("same_edge_valids", {bvalid, rvalid}, 2'b11);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        rd(8'h04, 3'b000, 32'h12345678, 2'b00);

`ifdef AXIL_REGFILE_PROT_EN
        wr(8'h00, 32'hA5A5A5A5, 4'hF, 3'b000, 2'b10);
        rd(8'h00, 3'b001, 32'h0, 2'b00);
        wr(8'h00, 32'hA5A5A5A5, 4'hF, 3'b001, 2'b00);
        rd(8'h00, 3'b000, 32'h0, 2'b10);
        rd(8'h00, 3'b001, 32'hA5A5A5A5, 2'b00);
`else
        wr(8'h00, 32'hA5A5A5A5, 4'hF, 3'b000, 2'b00);
        rd(8'h00, 3'b000, 32'hA5A5A5A5, 2'b00);
`endif

        // Reset with a read pending and an AW half latched
        araddr = 8'h08; arvalid = 1'b1; awaddr = 8'h10; awvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0;
        tick();
        chk("stall_rvalid", rvalid, 1'b1);
        chk("stall_rdata", rdata, 32'h11BB33DD);
        areset = 1'b1;
        tick();
        chk("mid_rst_valids", {bvalid, rvalid}, 2'b00);
        chk("mid_rst_rdata", rdata, 32'h0);
        areset = 1'b0;
        #1;
        chk("mid_rst_readies", {awready, wready, arready}, 3'b111);
        wdata = 32'h600DCAFE; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("aw_half_discarded", bvalid, 1'b0);
        awaddr = 8'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("late_aw_bvalid", bvalid, 1'b1);
        b_accept();
        rd(8'h04, 3'b000, 32'h0, 2'b00);
        rd(8'h08, 3'b000, 32'h0, 2'b00);
        rd(8'h0C, 3'b000, 32'h0, 2'b00);
        rd(8'h10, 3'b000, 32'h0, 2'b00);
        rd(8'h14, 3'b000, 32'h600DCAFE, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile_slave.md
AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

Interface
REQ-001 Parameter DATA_W, 32, data bus width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, 8, byte-address width of awaddr/araddr.
REQ-003 Parameter NUM_REGS, 16, number of DATA_W-bit registers; SHALL be ≥2 and ≤2^(ADDR_W-log2(DATA_W/8)).
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  reset; synchronous and active-high.
REQ-006 awaddr in ADDR_W; awprot in 3; awvalid in 1; awready out 1  write-address channel.
REQ-007 wdata in DATA_W; wstrb in DATA_W/8; wvalid in 1; wready out 1  write-data channel.
REQ-008 bresp out 2; bvalid out 1; bready in 1  write-response channel.
REQ-009 araddr in ADDR_W; arprot in 3; arvalid in 1; arready out 1  read-address channel.
REQ-010 rdata out DATA_W; rresp out 2; rvalid out 1; rready in 1  read-data channel.

Function
REQ-011 Word index SHALL be addr >> log2(DATA_W/8); low byte-offset bits ignored.
REQ-012 Index ≥ NUM_REGS SHALL give resp SLVERR (2'b10): no write, rdata 0; otherwise resp OKAY (2'b00).
REQ-013 Write FSM states: W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
REQ-014 awready = 1 in W_IDLE and W_DATA; wready = 1 in W_IDLE and W_ADDR; both 0 in W_RESP.
REQ-015 W_IDLE: AW and W handshake on the same edge -> commit that edge, go to W_RESP; AW only -> latch addr/prot, go to W_ADDR; W only -> latch data/strb, go to W_DATA.
REQ-016 W_ADDR on W handshake, or W_DATA on AW handshake -> commit using latched + live fields, go to W_RESP.
REQ-017 Commit SHALL update only bytes whose wstrb bit is 1; wstrb = 0 SHALL still return OKAY with no change.
REQ-018 W_RESP: bvalid = 1 with bresp stable until the bvalid&&bready edge, then W_IDLE; bvalid is registered, never combinational from inputs.
REQ-019 Read FSM states: R_IDLE (arready = 1, rvalid = 0), R_RESP (arready = 0, rvalid = 1).
REQ-020 AR handshake at edge N SHALL register rdata/rresp at edge N; rvalid high from cycle N+1 and held until the rvalid&&rready edge, then R_IDLE.
REQ-021 rdata/rresp SHALL stay stable while rvalid=1 and rready=0.
REQ-022 Read and write channels are independent; a read and a commit may complete on the same edge.
REQ-023 Read accepted on the same edge as a commit to the same index SHALL return the pre-write value.
REQ-024 Maximum throughput: one write per 2 cycles, one read per 2 cycles.

Reset
REQ-025 areset sampled high SHALL on that edge clear all registers to 0 and force W_IDLE, R_IDLE.
REQ-026 While areset is high, awready, wready and arready SHALL be 0. All three SHALL be 1 in the first cycle after deassertion.
REQ-027 Outputs after reset: bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-028 Reset mid-transaction SHALL discard latched AW/W halves and pending responses; no commit occurs on the reset edge.

Configuration
REQ-029 Macro AXIL_REGFILE_PROT_EN defined: an access with prot[0]=0 (unprivileged) to index 0 SHALL return SLVERR. Such a write SHALL not modify the register and such a read SHALL return rdata 0.
REQ-030 Macro AXIL_REGFILE_PROT_EN undefined: awprot/arprot SHALL be ignored.

Verification
REQ-031 Same-cycle AW(0x04)+W(0xDEADBEEF, strb 0xF), then read 0x04 -> bresp 00 one cycle later; rdata 0xDEADBEEF, rresp 00.
REQ-032 Reg 0x08=0x11223344; write 0xAABBCCDD strb 0x5 -> read returns 0x11BB33DD.
REQ-033 W two cycles before AW (addr 0x0C), bready held 0 for 3 cycles -> awready low during W_RESP. bvalid held with bresp 00; reg 0x0C written exactly once.
REQ-034 Write/read addr 4*NUM_REGS (0x40, defaults) -> bresp 10, rresp 10, rdata 0, no register changed.
REQ-035 Read pending with rready=0, areset pulsed one cycle -> rvalid 0 next cycle, all regs 0, readies 1 after release.
REQ-036 With AXIL_REGFILE_PROT_EN: write index 0 with awprot=000 -> bresp 10, reg unchanged; with awprot=001 -> bresp 00, written.
